// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multi-cycle multiply/divide unit with
// architectural HI/LO registers. Decodes the R-type HI/LO instructions,
// runs a one-bit-per-cycle shift-add multiplier or restoring divider,
// and stalls dependent HI/LO instructions while an operation is in flight.
module muldiv_unit #(
  parameter int NB_DATA   = 32,
  parameter int NB_FCODE  = 6,
  parameter int NB_OPCODE = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_FCODE-1:0]  i_funct_code,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  output logic                 o_stall,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_result_valid,
  output logic                 o_busy,
  output logic [NB_DATA-1:0]   o_hi,
  output logic [NB_DATA-1:0]   o_lo,
  output logic                 o_div_by_zero
);

  localparam int CW = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_FCODE-1:0] F_MFHI  = NB_FCODE'(6'h10);
  localparam logic [NB_FCODE-1:0] F_MTHI  = NB_FCODE'(6'h11);
  localparam logic [NB_FCODE-1:0] F_MFLO  = NB_FCODE'(6'h12);
  localparam logic [NB_FCODE-1:0] F_MTLO  = NB_FCODE'(6'h13);
  localparam logic [NB_FCODE-1:0] F_MULT  = NB_FCODE'(6'h18);
  localparam logic [NB_FCODE-1:0] F_MULTU = NB_FCODE'(6'h19);
  localparam logic [NB_FCODE-1:0] F_DIV   = NB_FCODE'(6'h1A);
  localparam logic [NB_FCODE-1:0] F_DIVU  = NB_FCODE'(6'h1B);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  state_t state;
  state_t state_next;

  // Decode
  logic is_rtype;
  logic fn_mfhi, fn_mthi, fn_mflo, fn_mtlo;
  logic fn_mult, fn_multu, fn_div, fn_divu;
  logic fn_any, fn_div_any, op_signed;
  logic is_idle, accept, start;

  // Operand preparation
  logic               rs_neg, rt_neg;
  logic [NB_DATA-1:0] rs_mag, rt_mag;

  // Iteration state: prod holds {partial/remainder, multiplier/quotient}
  logic [2*NB_DATA-1:0] prod;
  logic [NB_DATA-1:0]   opnd;
  logic [NB_DATA-1:0]   rs_orig;
  logic [CW-1:0]        count;
  logic                 op_div;
  logic                 neg_lo;
  logic                 neg_hi;
  logic                 dz;

  // Step datapath
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] mul_next;
  logic [NB_DATA:0]     div_shift;
  logic                 div_ge;
  logic [NB_DATA-1:0]   div_diff;
  logic [2*NB_DATA-1:0] div_next;

  // Sign-corrected results
  logic [2*NB_DATA-1:0] prod_neg;
  logic [NB_DATA-1:0]   fix_hi, fix_lo;

  // Architectural registers and control
  logic [NB_DATA-1:0] hi_q, lo_q;
  logic               rd_ok;
  logic               fix_write;

  // Instruction decode and acceptance
  always_comb begin
    is_rtype   = i_valid && (i_opcode == '0);
    fn_mfhi    = (i_funct_code == F_MFHI);
    fn_mthi    = (i_funct_code == F_MTHI);
    fn_mflo    = (i_funct_code == F_MFLO);
    fn_mtlo    = (i_funct_code == F_MTLO);
    fn_mult    = (i_funct_code == F_MULT);
    fn_multu   = (i_funct_code == F_MULTU);
    fn_div     = (i_funct_code == F_DIV);
    fn_divu    = (i_funct_code == F_DIVU);
    fn_any     = fn_mfhi | fn_mthi | fn_mflo | fn_mtlo |
                 fn_mult | fn_multu | fn_div | fn_divu;
    fn_div_any = fn_div | fn_divu;
    op_signed  = fn_mult | fn_div;
    is_idle    = (state == ST_IDLE);
    accept     = is_rtype && fn_any && is_idle && !i_flush;
    start      = accept && (fn_mult | fn_multu | fn_div | fn_divu);
  end

  // Operand magnitudes for the unsigned iterative core
  always_comb begin
    rs_neg = op_signed && i_rs_data[NB_DATA-1];
    rt_neg = op_signed && i_rt_data[NB_DATA-1];
    rs_mag = rs_neg ? (~i_rs_data + 1'b1) : i_rs_data;
    rt_mag = rt_neg ? (~i_rt_data + 1'b1) : i_rt_data;
  end

  // One multiply step and one restoring-divide step, selected by op_div
  always_comb begin
    mul_sum  = {1'b0, prod[2*NB_DATA-1:NB_DATA]} +
               (prod[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, prod[NB_DATA-1:1]};
    // Shifted remainder can reach NB_DATA+1 bits; the N-bit modular
    // difference is still exact whenever the trial subtract succeeds.
    div_shift = {prod[2*NB_DATA-1:NB_DATA], prod[NB_DATA-1]};
    div_ge    = div_shift[NB_DATA] || (div_shift[NB_DATA-1:0] >= opnd);
    div_diff  = div_shift[NB_DATA-1:0] - opnd;
    div_next  = div_ge ? {div_diff, prod[NB_DATA-2:0], 1'b1}
                       : {div_shift[NB_DATA-1:0], prod[NB_DATA-2:0], 1'b0};
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    prod_neg = ~prod + 1'b1;
    fix_hi   = '0;
    fix_lo   = '0;
    if (op_div) begin
      if (dz) begin
        fix_lo = '1;
        fix_hi = rs_orig;
      end else begin
        fix_lo = neg_lo ? (~prod[NB_DATA-1:0] + 1'b1) : prod[NB_DATA-1:0];
        fix_hi = neg_hi ? (~prod[2*NB_DATA-1:NB_DATA] + 1'b1)
                        : prod[2*NB_DATA-1:NB_DATA];
      end
    end else begin
      fix_lo = neg_lo ? prod_neg[NB_DATA-1:0] : prod[NB_DATA-1:0];
      fix_hi = neg_lo ? prod_neg[2*NB_DATA-1:NB_DATA]
                      : prod[2*NB_DATA-1:NB_DATA];
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // FSM next-state logic; flush wins over completion
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (i_flush)          state_next = ST_IDLE;
        else if (count == '0) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stall, MFHI/MFLO read port, HI/LO write strobe, pulse
  always_comb begin
    o_busy         = !is_idle;
    o_stall        = is_rtype && fn_any && !is_idle;
    rd_ok          = is_rtype && is_idle && !i_flush;
    o_result_valid = rd_ok && (fn_mfhi || fn_mflo);
    o_result       = '0;
    if (rd_ok && fn_mfhi)      o_result = hi_q;
    else if (rd_ok && fn_mflo) o_result = lo_q;
    fix_write      = (state == ST_FIX) && !i_flush;
    o_div_by_zero  = fix_write && op_div && dz;
  end

  // Operand latch at acceptance and per-cycle iteration in RUN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prod    <= '0;
      opnd    <= '0;
      rs_orig <= '0;
      count   <= '0;
      op_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      dz      <= 1'b0;
    end else if (start) begin
      prod    <= {{NB_DATA{1'b0}}, (fn_div_any ? rs_mag : rt_mag)};
      opnd    <= fn_div_any ? rt_mag : rs_mag;
      rs_orig <= i_rs_data;
      count   <= CW'(NB_DATA - 1);
      op_div  <= fn_div_any;
      neg_lo  <= rs_neg ^ rt_neg;
      neg_hi  <= rs_neg;
      dz      <= fn_div_any && (i_rt_data == '0);
    end else if ((state == ST_RUN) && !i_flush) begin
      prod  <= op_div ? div_next : mul_next;
      count <= count - 1'b1;
    end
  end

  // HI/LO registers: result write at FIX, MTHI/MTLO in IDLE
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_write) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else begin
      if (accept && fn_mthi) hi_q <= i_rs_data;
      if (accept && fn_mtlo) lo_q <= i_rs_data;
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Execute-stage multi-cycle multiply/divide unit with architectural HI/LO registers. It decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and runs an iterative shift-add multiplier or restoring divider, one bit per cycle. Sits beside the single-cycle ALU and its decoder. It raises a stall to the hazard unit when a dependent HI/LO instruction arrives while it is busy.

Parameters:
NB_DATA, 32, operand/HI/LO width (>=4)
NB_FCODE, 6, funct field width
NB_OPCODE, 6, opcode field width

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_valid  in  1  EX holds a real instruction (0 = bubble)
i_flush  in  1  squash the in-flight mul/div
i_opcode  in  NB_OPCODE  instruction opcode
i_funct_code  in  NB_FCODE  instruction funct
i_rs_data  in  NB_DATA  rs operand (multiplicand/dividend, MTHI/MTLO source)
i_rt_data  in  NB_DATA  rt operand (multiplier/divisor)
o_stall  out  1  hold the pipeline this cycle
o_result  out  NB_DATA  HI for MFHI, LO for MFLO, else 0
o_result_valid  out  1  MFHI/MFLO result is valid this cycle
o_busy  out  1  state != IDLE
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register
o_div_by_zero  out  1  one-cycle pulse when a divide by zero completes

Behaviour:
- The unit is active only when i_valid=1 and opcode=0x00. Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Every other code is ignored.
- Reset: asynchronous, active-low.
  - All outputs and all state go to 0, state=IDLE.
  - Reset asserted mid-operation aborts the operation immediately.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on an accepted MULT*/DIV*. The operand absolute values (signed ops) or raw values (unsigned ops) and the result sign are latched. The counter is loaded with NB_DATA-1.
  - RUN: one shift-add or restore-subtract step per cycle. The counter decrements each cycle. After NB_DATA cycles -> FIX.
  - FIX: apply sign correction, write HI/LO at the end of the cycle, -> IDLE.
  - Total busy time is NB_DATA+1 cycles after the accepting edge.
- Stall rule:
  - o_stall=1 (combinational) when i_valid, opcode=0, funct is any of the 8 codes, and state!=IDLE.
  - The pipeline holds the instruction stable while stalled. It is accepted in the first IDLE cycle.
  - MULT/DIV in IDLE does not stall; it is fire-and-forget.
- MFHI/MFLO:
  - In IDLE: o_result=HI or LO combinationally, o_result_valid=1.
  - When stalled: o_result_valid=0 and o_result=0.
- MTHI/MTLO in IDLE: HI or LO <= i_rs_data at the edge.
- Multiply: the 2*NB_DATA-bit product goes HI=upper half, LO=lower half. Signed results use two's complement.
- Divide:
  - LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- Divide by zero (signed or unsigned):
  - Same latency as a normal divide.
  - At FIX: LO=all ones, HI=original i_rs_data, and o_div_by_zero pulses for exactly the FIX cycle.
- Flush:
  - i_flush=1 in RUN or FIX -> IDLE at the next edge. HI/LO are unchanged and no o_div_by_zero pulse occurs.
  - i_flush in IDLE blocks acceptance of any instruction that cycle.
- Simultaneous events: flush has priority over FIX completion. A new MULT presented in the FIX cycle is stalled and accepted in the following IDLE cycle, which issues back-to-back with no extra bubble.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE; a MULT with the same operands gives HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100, o_div_by_zero high for 1 cycle only.
- MULT 6*7 accepted at cycle 0, MFLO presented at cycle 1:
  - o_stall=1 for cycles 1-33.
  - Cycle 34: o_result=42, o_result_valid=1.
- MTLO 0x55 then DIV started; i_flush at cycle 10 -> o_busy=0 at cycle 11, LO stays 0x55, no pulse. A separate run with reset_n=0 mid-RUN -> o_busy, o_hi, o_lo and o_stall all 0 immediately.
